// File: rtl/npu_pkg.sv
// npu_pkg -- shared definitions for the int8 dot-product sequencer.
//   state_e     : sequencer state enumeration (IDLE, CLEAR, FEED, DRAIN, DONE)
//   OP_W        : int8 operand width
//   ACC_W       : accumulator / result width
//   SAT_MAX/MIN : signed 16-bit saturation limits, held at accumulator width
//   sat_acc()   : clamp an accumulator value into [SAT_MIN, SAT_MAX]
`timescale 1ns/1ps
package npu_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 32;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 32'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -32'sd32768;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Clamp to the signed 16-bit range; the result stays sign-extended to ACC_W.
  function automatic logic [ACC_W-1:0] sat_acc(input logic signed [ACC_W-1:0] i_val);
    logic [ACC_W-1:0] v_res;
    if (i_val > SAT_MAX) begin
      v_res = SAT_MAX;
    end else if (i_val < SAT_MIN) begin
      v_res = SAT_MIN;
    end else begin
      v_res = i_val;
    end
    return v_res;
  endfunction

endpackage

// File: rtl/dot_sat.sv
// dot_sat -- combinational saturation of a 32-bit accumulator to the signed
// 16-bit range, sign-extended back to 32 bits.
//   i_acc : accumulator value (two's complement)
//   o_res : saturated, sign-extended result
// Only present in builds with NPU_DOT_SAT_EN defined, which is the only case
// in which mac_dot_seq instantiates it.
`timescale 1ns/1ps
`ifdef NPU_DOT_SAT_EN
module dot_sat
  import npu_pkg::*;
(
  input  logic [ACC_W-1:0] i_acc,
  output logic [ACC_W-1:0] o_res
);

  // Clamp the accumulator into the 16-bit signed window.
  always_comb begin
    o_res = sat_acc($signed(i_acc));
  end

endmodule
`endif

// File: rtl/mac_dot_seq.sv
// mac_dot_seq -- sequencer that streams int8 operand pairs into an external
// multiply-accumulate unit and returns the accumulated dot product.
//   clk, rst                       : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_len    : command handshake carrying the pair count
//   op_valid/op_ready/op_a/op_b    : operand beat handshake (signed int8)
//   mac_a/mac_b/mac_acc_clear      : drive to the MAC; zero operands on idle cycles
//   mac_acc                        : accumulator returned by the MAC
//   res_valid/res_ready/res_data   : result handshake (held until consumed)
//   busy                           : sequencer is not IDLE
// Build option: NPU_DOT_SAT_EN saturates res_data to the signed 16-bit range.
`timescale 1ns/1ps
module mac_dot_seq
  import npu_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  output logic [OP_W-1:0]   mac_a,
  output logic [OP_W-1:0]   mac_b,
  output logic              mac_acc_clear,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy
);

  // DRAIN counts 0..MAC_LAT; the capture happens on the cycle the count equals MAC_LAT.
  localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  state_e             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [OP_W-1:0]    r_mac_a;
  logic [OP_W-1:0]    r_mac_b;
  logic               r_clear;
  logic               r_res_valid;
  logic [ACC_W-1:0]   r_res_data;
  logic               r_op_ready;
  logic               r_cmd_ready;
  logic               r_busy;

  logic               w_beat;
  logic [LEN_W-1:0]   w_cnt_inc;
  logic [ACC_W-1:0]   w_res_next;

  // op_ready is only ever high in FEED, so a beat implies FEED.
  assign w_beat    = op_valid & r_op_ready;
  // The last beat leaves r_cnt at most 2^LEN_W-2 before the increment, so no wrap.
  assign w_cnt_inc = r_cnt + LEN_W'(1);

`ifdef NPU_DOT_SAT_EN
  logic [ACC_W-1:0] w_res_sat;

  dot_sat u_dot_sat (
    .i_acc (mac_acc),
    .o_res (w_res_sat)
  );

  assign w_res_next = w_res_sat;
`else
  assign w_res_next = mac_acc;
`endif

  // Sequencer FSM; every output is a register updated with the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_drain_cnt <= '0;
      r_mac_a     <= 8'd0;
      r_mac_b     <= 8'd0;
      r_clear     <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= 32'd0;
      r_op_ready  <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      // Accepted beats pass straight through; every other cycle feeds zeros.
      r_mac_a <= w_beat ? op_a : 8'd0;
      r_mac_b <= w_beat ? op_b : 8'd0;
      r_clear <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_len       <= cmd_len;
            r_cnt       <= '0;
            r_clear     <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_CLEAR;
          end else begin
            r_state     <= ST_IDLE;
          end
        end

        ST_CLEAR: begin
          r_drain_cnt <= '0;
          if (r_len != '0) begin
            r_op_ready <= 1'b1;
            r_state    <= ST_FEED;
          end else begin
            r_state    <= ST_DRAIN;
          end
        end

        ST_FEED: begin
          if (w_beat) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              r_op_ready <= 1'b0;
              r_state    <= ST_DRAIN;
            end else begin
              r_state    <= ST_FEED;
            end
          end else begin
            r_state <= ST_FEED;
          end
        end

        ST_DRAIN: begin
          // One cycle for the last operands to reach the MAC, MAC_LAT for it to add.
          if (r_drain_cnt == DRAIN_W'(MAC_LAT)) begin
            r_res_data  <= w_res_next;
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
            r_state     <= ST_DRAIN;
          end
        end

        ST_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state     <= ST_DONE;
          end
        end

        default: begin
          r_op_ready  <= 1'b0;
          r_res_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign op_ready      = r_op_ready;
  assign mac_a         = r_mac_a;
  assign mac_b         = r_mac_b;
  assign mac_acc_clear = r_clear;
  assign res_valid     = r_res_valid;
  assign res_data      = r_res_data;
  assign busy          = r_busy;

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq -- self-checking bench for mac_dot_seq with a behavioural
// int8 MAC attached (acc <= clear ? 0 : acc + a*b, one cycle latency).
// Expected results are dot products computed from the operand lists.
// Build option: NPU_DOT_SAT_EN also enables the saturation scenarios.
`timescale 1ns/1ps
module tb_mac_dot_seq;

  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [7:0]        op_a = 8'd0;
  logic [7:0]        op_b = 8'd0;
  logic [7:0]        mac_a;
  logic [7:0]        mac_b;
  logic              mac_acc_clear;
  logic signed [31:0] mac_acc;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [31:0]       res_data;
  logic              busy;

  int n_checks = 0;
  int n_fails  = 0;

  int qa[$];
  int qb[$];

  mac_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .mac_a         (mac_a),
    .mac_b         (mac_b),
    .mac_acc_clear (mac_acc_clear),
    .mac_acc       (mac_acc),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Behavioural int8 MAC with a one-cycle update.
  always @(posedge clk) begin
    if (mac_acc_clear) mac_acc <= 32'sd0;
    else               mac_acc <= mac_acc + $signed(mac_a) * $signed(mac_b);
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Operand-path monitor: mac_a/mac_b must show last cycle's accepted beat, else zero.
  logic [7:0] exp_a, exp_b;
  logic       armed = 1'b0;
  int         clr_total = 0;
  int         rdy_total = 0;

  always @(posedge clk) begin
    exp_a <= rst ? 8'd0 : ((op_valid && op_ready) ? op_a : 8'd0);
    exp_b <= rst ? 8'd0 : ((op_valid && op_ready) ? op_b : 8'd0);
    armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("mac_a_path", mac_a, exp_a);
      chk("mac_b_path", mac_b, exp_b);
      if (!rst && mac_acc_clear) clr_total++;
      if (op_ready) rdy_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint dot_ref(input int len);
    longint s = 0;
    for (int i = 0; i < len; i++) s += longint'(qa[i]) * longint'(qb[i]);
`ifdef NPU_DOT_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s;
  endfunction

  task automatic fill_rand(input int len);
    qa.delete();
    qb.delete();
    for (int i = 0; i < len; i++) begin
      qa.push_back(int'($urandom_range(0, 255)) - 128);
      qb.push_back(int'($urandom_range(0, 255)) - 128);
    end
  endtask

  task automatic fill_const(input int len, input int a, input int b);
    qa.delete();
    qb.delete();
    for (int i = 0; i < len; i++) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  // One full command; mode 0 = back-to-back, 1 = one bubble between beats, 2 = random bubbles.
  task automatic run_cmd(input string tag, input int len, input int mode, input int hold);
    longint exp;
    int g, idx, e, clr_base, rdy_base;
    logic hs, bub;
    exp      = dot_ref(len);
    clr_base = clr_total;
    rdy_base = rdy_total;
    cmd_len   = LEN_W'(len);
    cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 100) begin tick(); g++; end
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    idx = 0; bub = 1'b0; g = 0;
    while (idx < len && g < len * 4 + 50) begin
      if (bub) begin
        op_valid = 1'b0;
      end else begin
        op_valid = 1'b1;
        op_a = 8'(qa[idx]);
        op_b = 8'(qb[idx]);
      end
      hs = op_valid && op_ready;
      tick();
      g++;
      if (hs) begin
        idx++;
        bub = (mode == 1) || (mode == 2 && $urandom_range(0, 2) == 0);
      end else if (bub) begin
        bub = (mode == 2) && ($urandom_range(0, 3) == 0);
      end
    end
    op_valid = 1'b0;
    chk({tag, "_beats"}, idx, len);
    e = 0;
    while (!res_valid && e < 50) begin tick(); e++; end
    chk({tag, "_latency"}, e, (len > 0) ? 1 + MAC_LAT : 2 + MAC_LAT);
    chk({tag, "_res_data"}, $signed(res_data), exp);
    cmd_valid = (hold > 0);
    cmd_len   = LEN_W'(1);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_data"}, $signed(res_data), exp);
      chk({tag, "_hold_valid"}, res_valid, 1);
      chk({tag, "_hold_cmd_ready"}, cmd_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    chk({tag, "_res_valid_low"}, res_valid, 0);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_cmd_ready_idle"}, cmd_ready, 1);
    chk({tag, "_clear_pulses"}, clr_total - clr_base, 1);
    if (len == 0) chk({tag, "_op_ready_cycles"}, rdy_total - rdy_base, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=1 expected=0");
    $fatal(1);
  end

  initial begin
    int hs_cnt, g, rv_seen, len;

    // Reset values while rst is held.
    repeat (3) tick();
    chk("rst_clear", mac_acc_clear, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_mac_a", mac_a, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_clear_low", mac_acc_clear, 0);
    chk("idle_cmd_ready", cmd_ready, 1);

    // Directed: back-to-back, bubbled, and empty commands.
    qa = '{2, 4};
    qb = '{3, 5};
    chk("ref_26", dot_ref(2), 26);
    run_cmd("len2", 2, 0, 0);

    qa = '{-1, 3, 10};
    qb = '{7, -2, 10};
    chk("ref_87", dot_ref(3), 87);
    run_cmd("len3_bubble", 3, 1, 0);

    run_cmd("len0", 0, 0, 0);

    // Result held while a new command waits, then that command goes through.
    fill_rand(3);
    run_cmd("hold", 3, 0, 5);
    fill_rand(2);
    run_cmd("after_hold", 2, 2, 0);

    // Reset in the middle of FEED after two beats.
    fill_rand(4);
    cmd_len   = LEN_W'(4);
    cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 100) begin tick(); g++; end
    tick();
    cmd_valid = 1'b0;
    hs_cnt = 0; g = 0;
    while (hs_cnt < 2 && g < 50) begin
      op_valid = 1'b1;
      op_a = 8'(qa[hs_cnt]);
      op_b = 8'(qb[hs_cnt]);
      if (op_ready) hs_cnt++;
      tick();
      g++;
    end
    op_valid = 1'b0;
    chk("rst_mid_beats", hs_cnt, 2);
    rst = 1'b1;
    tick();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mac_a", mac_a, 0);
    chk("rst_mid_op_ready", op_ready, 0);
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid) rv_seen++;
    end
    chk("rst_mid_no_result", rv_seen, 0);
    fill_const(1, 127, 127);
    chk("ref_16129", dot_ref(1), 16129);
    run_cmd("after_rst", 1, 0, 0);

    // Random commands with random bubbles.
    for (int k = 0; k < 6; k++) begin
      len = int'($urandom_range(1, 12));
      fill_rand(len);
      run_cmd("rand", len, 2, int'($urandom_range(0, 2)));
    end

    // Longest command the length field can express.
    fill_rand((1 << LEN_W) - 1);
    run_cmd("len_max", (1 << LEN_W) - 1, 0, 0);

`ifdef NPU_DOT_SAT_EN
    fill_const(4, 127, 127);
    chk("ref_sat_pos", dot_ref(4), 32767);
    run_cmd("sat_pos", 4, 0, 0);
    fill_const(4, -128, 127);
    chk("ref_sat_neg", dot_ref(4), -32768);
    run_cmd("sat_neg", 4, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
